// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and clear-FSM state type for the multiport register file
package rf_pkg;
    localparam int RF_DW = 32;
    localparam int RF_AW = 5;
    localparam int RF_NR = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;
endpackage

// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - decode/writeback bus of the register file; RF_DEBUG_PORT_EN adds dbg_ra/dbg_rd
interface rf_multiport_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic             we;
    logic             busy;
`ifdef RF_DEBUG_PORT_EN
    logic [AW-1:0]    dbg_ra;
    logic [DW-1:0]    dbg_rd;
`endif

    modport master (
        output ra, wa, wd, we,
`ifdef RF_DEBUG_PORT_EN
        output dbg_ra,
        input  dbg_rd,
`endif
        input  rd, busy
    );

    modport slave (
        input  ra, wa, wd, we,
`ifdef RF_DEBUG_PORT_EN
        input  dbg_ra,
        output dbg_rd,
`endif
        output rd, busy
    );
endinterface

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - post-reset sequencer that sweeps zeros through every register entry
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    localparam logic [AW:0] LAST = (AW+1)'((1 << AW) - 1);

    rf_state_e   state;
    logic [AW:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: ;
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // The reset edge itself must leave the array untouched.
    assign clr_we   = (state == CLEAR) && !rst;
    assign clr_addr = cnt[AW-1:0];
endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - NR-read/1-write register file with zero register, write bypass and hardware clear
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int AW       = RF_AW,
    parameter int NR       = RF_NR,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    rf_multiport_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          ext_we;

    rf_clear_seq #(.AW(AW)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // External writes during the sweep are dropped outright, not deferred.
    assign ext_we = bus.we && !busy && !rst && !(ZERO_REG != 0 && bus.wa == '0);

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (ext_we)
            mem[bus.wa] <= bus.wd;
    end

    assign bus.busy = busy;

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0] ra_g;
        assign ra_g = bus.ra[g*AW +: AW];
        assign bus.rd[g*DW +: DW] =
            busy                           ? '0     :
            (ZERO_REG != 0 && ra_g == '0)  ? '0     :
            (bus.we && bus.wa == ra_g)     ? bus.wd :
                                             mem[ra_g];
    end

`ifdef RF_DEBUG_PORT_EN
    assign bus.dbg_rd = mem[bus.dbg_ra];
`endif
endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - scoreboard bench for rf_multiport (NR=4, DW=32, AW=5)
module tb_rf_multiport;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int WAIT_LIMIT_NS = 100000;

    typedef struct {
        int          tag;
        int          kind;   // 0: read port data, 1: busy
        int          port;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tag_ctr  = 0;
    logic done     = 1'b0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    rf_multiport_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

    rf_multiport #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input int port, input logic [31:0] v);
        exp_t e;
        e.tag = tag_ctr; e.kind = 0; e.port = port; e.val = v;
        tag_ctr++;
        q.push_back(e);
    endtask

    task automatic exp_busy(input logic b);
        exp_t e;
        e.tag = tag_ctr; e.kind = 1; e.port = 0; e.val = {31'b0, b};
        tag_ctr++;
        q.push_back(e);
    endtask

    task automatic set_ra(input int port, input int a);
        bus.ra[port*AW +: AW] = AW'(a);
    endtask

    // Monitor: the read path is combinational, so every expectation queued
    // during a cycle is checked at that cycle's falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            act = (e.kind == 1) ? {31'b0, bus.busy} : bus.rd[e.port*DW +: DW];
            n_checks++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL chk%0d %s port%0d: got %h expected %h", e.tag,
                         (e.kind == 1) ? "busy" : "rd", e.port, act, e.val);
            end
        end
    end

    initial begin
        #(WAIT_LIMIT_NS);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: test did not complete within %0d ns", WAIT_LIMIT_NS);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        bus.ra = '0; bus.wa = '0; bus.wd = '0; bus.we = 1'b0;
`ifdef RF_DEBUG_PORT_EN
        bus.dbg_ra = '0;
`endif
        // Reset held for two cycles
        step();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.rd !== '0) begin
            n_fail++;
            $display("FAIL reset state: busy=%b rd=%h", bus.busy, bus.rd);
        end
        exp_busy(1'b1);
        exp_rd(0, 32'h0);
        exp_rd(1, 32'h0);
        step();
        rst = 1'b0;

        // First sweep, with a dropped write attempt at clear cycle 10
        for (int k = 0; k <= 32; k++) begin
            if (k == 10) begin
                bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hA5;
                set_ra(0, 3);
                exp_rd(0, 32'h0);
            end else begin
                bus.we = 1'b0;
            end
            exp_busy(k < 32);
            step();
        end
        bus.we = 1'b0;

        for (int a = 0; a < 32; a++) begin
            set_ra(0, a); set_ra(1, a);
            exp_rd(0, 32'h0);
            exp_rd(1, 32'h0);
            step();
        end

        // Basic write then read on two ports
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEADBEEF;
        step();
        bus.we = 1'b0;
        set_ra(0, 5); set_ra(1, 5);
        exp_rd(0, 32'hDEADBEEF);
        exp_rd(1, 32'hDEADBEEF);
        step();

        // Same-cycle bypass
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h12345678;
        set_ra(0, 7); set_ra(1, 6);
        exp_rd(0, 32'h12345678);
        exp_rd(1, 32'h0);
        step();
        bus.we = 1'b0;
        exp_rd(0, 32'h12345678);
        step();

        // Zero register, both via bypass and after the write edge
        bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF;
        set_ra(0, 0);
        exp_rd(0, 32'h0);
        step();
        bus.we = 1'b0;
        exp_rd(0, 32'h0);
        step();

        // Random regression against a reference model on all four ports
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        model[5] = 32'hDEADBEEF;
        model[7] = 32'h12345678;
        for (int c = 0; c < 42; c++) begin
            logic        we_r;
            logic [4:0]  wa_r;
            logic [31:0] wd_r;
            int          ra_r [NR];
            we_r = 1'($urandom_range(0, 1));
            wa_r = 5'($urandom_range(0, 31));
            wd_r = $urandom;
            bus.we = we_r; bus.wa = wa_r; bus.wd = wd_r;
            for (int p = 0; p < NR; p++) begin
                ra_r[p] = (p == 0) ? int'(wa_r) : int'($urandom_range(0, 31));
                set_ra(p, ra_r[p]);
                if (ra_r[p] == 0)
                    exp_rd(p, 32'h0);
                else if (we_r && int'(wa_r) == ra_r[p])
                    exp_rd(p, wd_r);
                else
                    exp_rd(p, model[ra_r[p]]);
            end
            step();
            if (we_r && wa_r != 5'd0) model[wa_r] = wd_r;
        end
        bus.we = 1'b0;

        // Reset pulse in mid-clear restarts the full sweep
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_busy(1'b1);
            step();
        end
        rst = 1'b1;
        exp_busy(1'b1);
        step();
        rst = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            exp_busy(k < 32);
            step();
        end
        set_ra(0, 5); set_ra(1, 7);
        exp_rd(0, 32'h0);
        exp_rd(1, 32'h0);
        step();

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the 2-read/1-write 32x32 register file.
- Generalised in data width, address width and number of read ports.
- Adds a hardwired-zero register, write-to-read bypass, and a post-reset hardware clear sequencer.
- Sits in the datapath as the CPU general-purpose register file; the decode stage drives the read ports and writeback drives the write port.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW entries.
- NR, 2, number of read ports (1..8).
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ra  in  NR*AW  read addresses, packed; port i = ra[i*AW +: AW].
- rd  out  NR*DW  read data, packed; port i = rd[i*DW +: DW].
- wa  in  AW  write address.
- wd  in  DW  write data.
- we  in  1  write enable.
- busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset and clear FSM
  - States: CLEAR, RUN.
  - rst=1 at a rising edge: FSM -> CLEAR, clear counter cnt -> 0, busy=1. Array contents are not touched on the reset edge.
  - CLEAR: each cycle writes 0 to entry cnt, then cnt <= cnt+1.
  - When cnt = DEPTH-1 is written, the next state is RUN.
  - busy is high for exactly DEPTH cycles after the first clk edge with rst deasserted (reset cycle itself also busy=1).
  - RUN: holds until rst.
  - rst asserted mid-CLEAR: cnt restarts at 0 and the full sweep repeats.
- Writes
  - In RUN: when we=1 (and not (ZERO_REG and wa==0)), mem[wa] <= wd at the rising edge.
  - In CLEAR: external we is ignored and the write is dropped, not queued.
- Reads
  - Combinational, zero latency.
  - Per port i, priority order:
    1. busy=1 -> 0.
    2. ZERO_REG and ra_i==0 -> 0.
    3. Bypass: we=1 and wa==ra_i (RUN state) -> wd, so same-cycle write data is visible.
    4. Otherwise mem[ra_i].
  - All NR ports are independent; any number may read the same address; no port conflicts exist.
- Width rules: no truncation or extension; wd is stored verbatim, DW bits.
- Outputs at reset: busy=1, rd=0 on all ports (forced by busy).
- Simultaneous write and read of the same address in RUN: rd shows the new wd in that cycle and mem holds wd from the next cycle.
- Wrap-around: cnt is AW+1 bits wide so DEPTH terminates cleanly. No address wrap on ports, since AW spans the array exactly.

Optional Feature:
- Macro RF_DEBUG_PORT_EN.
- Defined: adds ports dbg_ra (in, AW) and dbg_rd (out, DW) for the board/debug unit.
  - dbg_rd = mem[dbg_ra] raw, with no bypass, no busy masking, and no zero forcing.
  - Lets the debugger observe clear progress.
- Undefined: the ports are absent and there is no extra read mux.

Decomposition:
- Package rf_pkg: default DW/AW/NR constants and an FSM state typedef {CLEAR, RUN}.
- Sub-module rf_clear_seq: owns the FSM and cnt; outputs busy, clr_we, clr_addr.
- rf_multiport top owns the storage array, write mux (clear vs external) and the NR read muxes via a generate loop.

Test Plan:
- Clear sequence: rst high 2 cycles then low, NR=2, AW=5 -> busy high for exactly 32 cycles after release; afterwards every address reads 0 on both ports.
- Basic write/read: write wa=5 wd=32'hDEADBEEF, next cycle ra0=5 ra1=5 -> both rd = 32'hDEADBEEF.
- Bypass: same cycle we=1 wa=7 wd=32'h12345678, ra0=7 -> rd0 = 32'h12345678 combinationally; ra1=6 unaffected.
- Zero register: write wa=0 wd=32'hFFFFFFFF, then ra0=0 -> rd0=0; also same-cycle bypass to 0 yields 0.
- Write during clear / reset mid-clear:
  - we=1 wa=3 wd=32'hA5 at clear cycle 10 -> after busy drops, ra=3 reads 0.
  - rst pulse at clear cycle 20 -> busy lasts 32 further cycles.
- Random regression: 42 cycles of random wa/wd/ra with NR=4 against a reference model -> no mismatch.
